// File: rtl/div_control.sv
// Sequencer for a 32-bit restoring divider sharing the main ALU.
// Steps INIT, then N x (SUB, TEST, SHIFT), then WAIT (final upper-half right shift) and DONE.
module div_control #(
  parameter int          N     = 32,
  parameter logic [5:0]  F_ADD = 6'b100000,
  parameter logic [5:0]  F_SUB = 6'b100010,
  parameter logic [5:0]  F_SLL = 6'b000000,
  parameter logic [5:0]  F_SRL = 6'b000010,
  parameter logic [5:0]  F_NOP = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       fsb,
  output logic       ready,
  output logic       ready_wait,
  output logic       wrctrl,
  output logic       ozctrl,
  output logic [5:0] ALUfunction
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SUB   = 3'd2,
    S_TEST  = 3'd3,
    S_SHIFT = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(N - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       neg_q, neg_d;

  // State, iteration counter and restore flag; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state and Moore output decode; only wrctrl in TEST looks at fsb.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    ALUfunction = F_NOP;
    wrctrl      = 1'b0;
    ozctrl      = 1'b0;
    ready       = 1'b0;
    ready_wait  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_INIT;
          cnt_d   = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        ALUfunction = F_SLL;
        state_d     = S_SUB;
      end
      S_SUB: begin
        ALUfunction = F_SUB;
        wrctrl      = 1'b1;
        state_d     = S_TEST;
      end
      S_TEST: begin
        // Write back the sum only when the trial subtraction went negative (restore).
        ALUfunction = F_ADD;
        wrctrl      = fsb;
        neg_d       = fsb;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        ALUfunction = F_SLL;
        ozctrl      = ~neg_q;
        if (cnt_q == LAST_ITER) begin
          state_d = S_WAIT;
        end else begin
          cnt_d   = cnt_q + 6'd1;
          state_d = S_SUB;
        end
      end
      S_WAIT: begin
        ALUfunction = F_SRL;
        ready_wait  = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        ready = 1'b1;
        if (run) begin
          state_d = S_INIT;
          cnt_d   = 6'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_control.sv
// Directed bench for div_control: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_div_control;

  logic       clk;
  logic       rst;
  logic       run;
  logic       fsb;
  logic       ready;
  logic       ready_wait;
  logic       wrctrl;
  logic       ozctrl;
  logic [5:0] ALUfunction;

  typedef struct packed {
    logic [5:0] alu;
    logic       wr;
    logic       oz;
    logic       rdy;
    logic       rw;
  } exp_t;

  localparam exp_t E_IDLE  = '{alu: 6'b111111, wr: 1'b0, oz: 1'b0, rdy: 1'b0, rw: 1'b0};
  localparam exp_t E_INIT  = '{alu: 6'b000000, wr: 1'b0, oz: 1'b0, rdy: 1'b0, rw: 1'b0};
  localparam exp_t E_SUB   = '{alu: 6'b100010, wr: 1'b1, oz: 1'b0, rdy: 1'b0, rw: 1'b0};
  localparam exp_t E_WAIT  = '{alu: 6'b000010, wr: 1'b0, oz: 1'b0, rdy: 1'b0, rw: 1'b1};
  localparam exp_t E_DONE  = '{alu: 6'b111111, wr: 1'b0, oz: 1'b0, rdy: 1'b1, rw: 1'b0};

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   cyc;

  div_control dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .fsb        (fsb),
    .ready      (ready),
    .ready_wait (ready_wait),
    .wrctrl     (wrctrl),
    .ozctrl     (ozctrl),
    .ALUfunction(ALUfunction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t got_vec();
    return '{alu: ALUfunction, wr: wrctrl, oz: ozctrl, rdy: ready, rw: ready_wait};
  endfunction

  // Monitor: compare each cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_vec();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cycle_%0d got alu=%b wr=%b oz=%b rdy=%b rw=%b required alu=%b wr=%b oz=%b rdy=%b rw=%b",
                 cyc, g.alu, g.wr, g.oz, g.rdy, g.rw, e.alu, e.wr, e.oz, e.rdy, e.rw);
      end
      cyc++;
    end
  end

  task automatic check_now(input string name, input exp_t e);
    exp_t g;
    g = got_vec();
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s got alu=%b wr=%b oz=%b rdy=%b rw=%b required alu=%b wr=%b oz=%b rdy=%b rw=%b",
               name, g.alu, g.wr, g.oz, g.rdy, g.rw, e.alu, e.wr, e.oz, e.rdy, e.rw);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_fsb(input int mode, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (i % 2 == 0) ? 1'b1 : 1'b0;
    endcase
  endfunction

  // Entered at posedge+1 of an IDLE/DONE cycle whose expectation is not yet queued.
  // Leaves at posedge+1 of the following cycle, again not yet queued.
  task automatic do_div(input int mode, input bit from_done, input bit inject,
                        input int abort_iter, input int hold);
    logic f;
    exp_t e;
    run = 1'b1;
    fsb = 1'b1;
    exp_q.push_back(from_done ? E_DONE : E_IDLE);
    step();
    run = 1'b0;
    fsb = 1'b0;
    exp_q.push_back(E_INIT);
    for (int i = 0; i < 32; i++) begin
      step();
      run = inject;
      fsb = 1'b1;
      exp_q.push_back(E_SUB);
      if (i == abort_iter) begin
        @(negedge clk);
        #2;
        rst = 1'b0;
        run = 1'b0;
        #1;
        check_now("abort_reset_immediate", E_IDLE);
        @(posedge clk);
        #1;
        check_now("abort_reset_held", E_IDLE);
        rst = 1'b1;
        return;
      end
      step();
      f   = pick_fsb(mode, i);
      fsb = f;
      e   = '{alu: 6'b100000, wr: f, oz: 1'b0, rdy: 1'b0, rw: 1'b0};
      exp_q.push_back(e);
      step();
      fsb = ~f;
      e   = '{alu: 6'b000000, wr: 1'b0, oz: ~f, rdy: 1'b0, rw: 1'b0};
      exp_q.push_back(e);
    end
    step();
    run = 1'b0;
    exp_q.push_back(E_WAIT);
    step();
    exp_q.push_back(E_DONE);
    for (int h = 0; h < hold; h++) begin
      step();
      fsb = h[0];
      exp_q.push_back(E_DONE);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b0;
    run      = 1'b1;
    fsb      = 1'b1;
    #1;
    check_now("reset_immediate", E_IDLE);
    step();
    check_now("reset_held_through_edge", E_IDLE);
    run = 1'b0;
    rst = 1'b1;
    step();
    exp_q.push_back(E_IDLE);
    step();
    exp_q.push_back(E_IDLE);
    step();

    do_div(0, 1'b0, 1'b0, -1, 3);
    do_div(1, 1'b1, 1'b1, -1, 2);
    do_div(2, 1'b1, 1'b0, -1, 2);
    do_div(0, 1'b1, 1'b0, 5, 0);
    exp_q.push_back(E_IDLE);
    step();
    do_div(2, 1'b0, 1'b1, -1, 2);

    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
